// File: rtl/sev_seg_capture_if.sv
// Scanned seven-segment display bus: one-hot active-low digit select
// plus active-low segment pattern {a,b,c,d,e,f,g}.
interface sev_seg_capture_if;
  logic [3:0] sel;
  logic [6:0] sev_seg;

  modport master (
    output sel,
    output sev_seg
  );

  modport slave (
    input sel,
    input sev_seg
  );
endinterface

// File: rtl/sev_seg_capture.sv
// Receive-side decoder for the multiplexed 4-digit seven-segment bus:
// glitch filter, pattern-to-BCD decode and frame assembly.
module sev_seg_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             clear_n,
  sev_seg_capture_if.slave bus,
  output logic [15:0]      digits,
  output logic             frame_valid,
  output logic             seg_err,
  output logic             err_sticky,
  output logic             stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETL,
    HOLD
  } state_t;

  state_t        state;
  logic [3:0]    sel_q;
  logic [6:0]    seg_q;
  logic [3:0]    snap_sel;
  logic [6:0]    snap_seg;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    seen;
  logic [3:0]    slot [4];
  logic          err_p;

  logic       legal;
  logic [1:0] idx;
  logic       seg_ok;
  logic [3:0] bcd;
  logic       same;
  logic       start;
  logic       accept;
  logic       good;
  logic       commit;
  logic       tmo;

  always_comb begin
    legal = 1'b0;
    idx   = 2'd0;
    case (sel_q)
      4'b1110: begin legal = 1'b1; idx = 2'd0; end
      4'b1101: begin legal = 1'b1; idx = 2'd1; end
      4'b1011: begin legal = 1'b1; idx = 2'd2; end
      4'b0111: begin legal = 1'b1; idx = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    seg_ok = 1'b1;
    bcd    = 4'd0;
    case (seg_q)
      7'h01:   bcd = 4'd0;
      7'h4F:   bcd = 4'd1;
      7'h12:   bcd = 4'd2;
      7'h06:   bcd = 4'd3;
      7'h4C:   bcd = 4'd4;
      7'h24:   bcd = 4'd5;
      7'h20:   bcd = 4'd6;
      7'h0F:   bcd = 4'd7;
      7'h00:   bcd = 4'd8;
      7'h04:   bcd = 4'd9;
      default: seg_ok = 1'b0;
    endcase
  end

  // A new dwell starts on any legal sample that is not the current snapshot.
  assign same   = {sel_q, seg_q} == {snap_sel, snap_seg};
  assign start  = legal && ((state == IDLE) || !same);
  assign accept = (start && (SETTLE == 1)) ||
                  ((state == SETL) && same && (cnt == CNT_LAST));
  assign good   = accept && seg_ok;
  assign commit = seen == 4'hF;
  assign tmo    = !accept && (tcnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state       <= IDLE;
      sel_q       <= 4'hF;
      seg_q       <= 7'h7F;
      snap_sel    <= 4'hF;
      snap_seg    <= 7'h7F;
      cnt         <= '0;
      tcnt        <= '0;
      seen        <= 4'h0;
      slot        <= '{default: 4'h0};
      err_p       <= 1'b0;
      digits      <= 16'h0000;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      err_sticky  <= 1'b0;
      stale       <= 1'b0;
    end else begin
      sel_q <= bus.sel;
      seg_q <= bus.sev_seg;

      if (start) begin
        snap_sel <= sel_q;
        snap_seg <= seg_q;
        cnt      <= CNT_ONE;
        state    <= accept ? HOLD : SETL;
      end else if (state == SETL) begin
        if (!same) begin
          state <= IDLE;
        end else if (accept) begin
          state <= HOLD;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if ((state == HOLD) && !same) begin
        state <= IDLE;
      end

      if (good) begin
        slot[idx] <= bcd;
      end
      seen <= ((commit || tmo) ? 4'h0 : seen) |
              (good ? (4'b0001 << idx) : 4'h0);

      err_p   <= accept && !seg_ok;
      seg_err <= err_p;
      if (err_p) begin
        err_sticky <= 1'b1;
      end

      frame_valid <= commit;
      if (commit) begin
        digits <= {slot[3], slot[2], slot[1], slot[0]};
      end

      if (accept) begin
        tcnt <= '0;
      end else if (tcnt != TO_MAX) begin
        tcnt <= tcnt + 1'b1;
      end

      if (commit) begin
        stale <= 1'b0;
      end else if (tmo) begin
        stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_capture.sv
// Bench for sev_seg_capture: directed scans plus random bus traffic,
// checked every cycle against a run-length behavioural model.
module tb_sev_seg_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;

  logic        clk;
  logic        clear_n;
  logic [15:0] digits;
  logic        frame_valid;
  logic        seg_err;
  logic        err_sticky;
  logic        stale;

  sev_seg_capture_if bus ();

  sev_seg_capture #(
    .SETTLE  (SETTLE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .bus         (bus),
    .digits      (digits),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .err_sticky  (err_sticky),
    .stale       (stale)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  logic [6:0] pat [10];

  initial begin
    pat[0] = 7'h01; pat[1] = 7'h4F; pat[2] = 7'h12; pat[3] = 7'h06;
    pat[4] = 7'h4C; pat[5] = 7'h24; pat[6] = 7'h20; pat[7] = 7'h0F;
    pat[8] = 7'h00; pat[9] = 7'h04;
  end

  function automatic int seg2bcd(logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (pat[i] == s) return i;
    end
    return -1;
  endfunction

  function automatic int slot_of(logic [3:0] s);
    int n;
    int p;
    n = 0;
    p = -1;
    for (int i = 0; i < 4; i++) begin
      if (!s[i]) begin
        n++;
        p = i;
      end
    end
    return (n == 1) ? p : -1;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a digit is accepted when a legal sample has repeated exactly
  // SETTLE times in a row; outputs follow from that event stream.
  bit          m_on = 0;
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_slot [4];
  bit   [3:0]  m_seen;
  logic [15:0] m_digits;
  bit          m_fv, m_err, m_sticky, m_stale, m_errp;
  int          m_idle;

  always @(posedge clk) begin
    bit full;
    bit acc;
    bit tmo;
    int s;
    int v;
    logic [10:0] cur;
    if (!clear_n) begin
      m_on     = 1;
      m_prev   = {4'hF, 7'h7F};
      m_run    = 0;
      m_seen   = 4'h0;
      m_digits = 16'h0;
      m_fv     = 0;
      m_err    = 0;
      m_sticky = 0;
      m_stale  = 0;
      m_errp   = 0;
      m_idle   = 0;
      for (int i = 0; i < 4; i++) m_slot[i] = 4'h0;
    end else if (m_on) begin
      full   = (m_seen == 4'hF);
      m_fv   = full;
      m_err  = m_errp;
      if (m_errp) m_sticky = 1;
      m_errp = 0;
      if (full) begin
        m_digits = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        m_seen   = 4'h0;
      end
      s   = slot_of(m_prev[10:7]);
      acc = (s >= 0) && (m_run == SETTLE);
      tmo = 0;
      if (acc) begin
        m_idle = 0;
        v = seg2bcd(m_prev[6:0]);
        if (v >= 0) begin
          m_slot[s] = 4'(v);
          m_seen[s] = 1'b1;
        end else begin
          m_errp = 1;
        end
      end else if (m_idle < TIMEOUT) begin
        m_idle++;
        if (m_idle == TIMEOUT) tmo = 1;
      end
      if (tmo) begin
        m_seen  = 4'h0;
        m_stale = 1;
      end
      if (full) m_stale = 0;
      cur = {bus.sel, bus.sev_seg};
      if (cur == m_prev) begin
        if (m_run <= SETTLE) m_run++;
      end else begin
        m_run = 1;
      end
      m_prev = cur;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("digits", digits, m_digits);
      chk("frame_valid", {15'd0, frame_valid}, {15'd0, m_fv});
      chk("seg_err", {15'd0, seg_err}, {15'd0, m_err});
      chk("err_sticky", {15'd0, err_sticky}, {15'd0, m_sticky});
      chk("stale", {15'd0, stale}, {15'd0, m_stale});
      if (frame_valid === 1'b1) fv_cnt++;
      if (seg_err === 1'b1) err_cnt++;
    end
  end

  task automatic drive(logic [3:0] s, logic [6:0] g, int n);
    @(negedge clk);
    bus.sel     = s;
    bus.sev_seg = g;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic settle_pt();
    @(negedge clk);
    #2;
  endtask

  int fv0;
  int e0;

  initial begin
    clear_n     = 1'b0;
    bus.sel     = 4'hF;
    bus.sev_seg = 7'h7F;

    // reset with toggling inputs
    repeat (2) begin
      @(negedge clk);
      bus.sel     = 4'($urandom);
      bus.sev_seg = 7'($urandom);
    end
    @(negedge clk);
    clear_n     = 1'b1;
    bus.sel     = 4'hF;
    bus.sev_seg = 7'h7F;
    #2;
    chk("rst_digits", digits, 16'h0000);
    chk("rst_pulses", {14'd0, frame_valid, seg_err}, 16'h0);
    chk("rst_flags", {14'd0, err_sticky, stale}, 16'h0);

    // clean scan 1,2,3,4
    fv0 = fv_cnt;
    e0  = err_cnt;
    drive(4'h7, 7'h4F, 8);
    drive(4'hB, 7'h12, 8);
    drive(4'hD, 7'h06, 8);
    drive(4'hE, 7'h4C, 8);
    drive(4'hF, 7'h7F, 4);
    settle_pt();
    chk("scan_fv_count", 16'(fv_cnt - fv0), 16'd1);
    chk("scan_digits", digits, 16'h1234);
    chk("scan_model", m_digits, 16'h1234);
    chk("scan_no_err", 16'(err_cnt - e0), 16'd0);

    // 2-cycle glitch on digit0 before its real dwell
    fv0 = fv_cnt;
    drive(4'h7, 7'h24, 8);
    drive(4'hB, 7'h20, 8);
    drive(4'hD, 7'h0F, 8);
    drive(4'hE, 7'h00, 2);
    drive(4'hE, 7'h04, 8);
    drive(4'hF, 7'h7F, 4);
    settle_pt();
    chk("glitch_fv_count", 16'(fv_cnt - fv0), 16'd1);
    chk("glitch_digits", digits, 16'h5679);

    // illegal pattern on digit2
    fv0 = fv_cnt;
    e0  = err_cnt;
    drive(4'h7, 7'h4F, 8);
    drive(4'hB, 7'h7F, 8);
    drive(4'hD, 7'h12, 8);
    drive(4'hE, 7'h06, 8);
    drive(4'hF, 7'h7F, 4);
    settle_pt();
    chk("illegal_err_count", 16'(err_cnt - e0), 16'd1);
    chk("illegal_sticky", {15'd0, err_sticky}, 16'd1);
    chk("illegal_no_frame", 16'(fv_cnt - fv0), 16'd0);
    drive(4'hB, 7'h4C, 8);
    drive(4'hF, 7'h7F, 4);
    settle_pt();
    chk("rescan_fv_count", 16'(fv_cnt - fv0), 16'd1);
    chk("rescan_digits", digits, 16'h1423);

    // timeout discards partial frame
    fv0 = fv_cnt;
    drive(4'h7, 7'h06, 8);
    drive(4'hB, 7'h12, 8);
    drive(4'hF, 7'h7F, TIMEOUT + 10);
    settle_pt();
    chk("timeout_stale", {15'd0, stale}, 16'd1);
    chk("timeout_digits_held", digits, 16'h1423);
    drive(4'hD, 7'h20, 8);
    drive(4'hE, 7'h0F, 8);
    drive(4'hF, 7'h7F, 4);
    settle_pt();
    chk("timeout_partial_dropped", 16'(fv_cnt - fv0), 16'd0);
    drive(4'h7, 7'h4C, 8);
    drive(4'hB, 7'h24, 8);
    drive(4'hF, 7'h7F, 4);
    settle_pt();
    chk("recover_fv_count", 16'(fv_cnt - fv0), 16'd1);
    chk("recover_digits", digits, 16'h4567);
    chk("recover_stale", {15'd0, stale}, 16'd0);

    // mid-frame reset
    drive(4'h7, 7'h4F, 8);
    drive(4'hB, 7'h12, 8);
    drive(4'hD, 7'h06, 8);
    @(negedge clk);
    clear_n     = 1'b0;
    bus.sel     = 4'hF;
    bus.sev_seg = 7'h7F;
    @(negedge clk);
    clear_n = 1'b1;
    #2;
    chk("midrst_digits", digits, 16'h0000);
    chk("midrst_sticky", {15'd0, err_sticky}, 16'd0);
    fv0 = fv_cnt;
    drive(4'h7, 7'h04, 8);
    drive(4'hB, 7'h00, 8);
    drive(4'hD, 7'h0F, 8);
    drive(4'hE, 7'h20, 8);
    drive(4'hF, 7'h7F, 4);
    settle_pt();
    chk("midrst_fv_count", 16'(fv_cnt - fv0), 16'd1);
    chk("midrst_digits_new", digits, 16'h9876);

    // random traffic: mostly legal scans, some glitches and junk
    for (int k = 0; k < 400; k++) begin
      logic [3:0] s;
      logic [6:0] g;
      int         r;
      logic [3:0] lg [4];
      lg[0] = 4'hE; lg[1] = 4'hD; lg[2] = 4'hB; lg[3] = 4'h7;
      r = int'($urandom_range(0, 9));
      s = (r < 8) ? lg[$urandom_range(0, 3)] : 4'($urandom);
      r = int'($urandom_range(0, 9));
      g = (r < 8) ? pat[$urandom_range(0, 9)] : 7'($urandom);
      drive(s, g, int'($urandom_range(1, 8)));
    end
    drive(4'hF, 7'h7F, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
